// File: rtl/lzrw1_pkg.sv
// Shared types and constants for the LZRW1 compressed-stream parser.
package lzrw1_pkg;

    localparam int LZRW1_GROUP_SIZE  = 8;
    localparam int LZRW1_COUNT_WIDTH = 16;

    localparam logic LZRW1_LITERAL = 1'b0;
    localparam logic LZRW1_COPY    = 1'b1;

    typedef enum logic [2:0] {
        GET_CW  = 3'd0,
        GET_B0  = 3'd1,
        GET_B1  = 3'd2,
        PRESENT = 3'd3,
        GAP     = 3'd4,
        DRAIN   = 3'd5,
        ERROR   = 3'd6
    } parser_state_t;

    typedef struct packed {
        logic [15:0] data;
        logic        is_copy;
    } item_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [LZRW1_COUNT_WIDTH-1:0] sat_inc(
        input logic [LZRW1_COUNT_WIDTH-1:0] value
    );
        return (&value) ? value : (value + {{(LZRW1_COUNT_WIDTH-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/lzrw1_stream_parser.sv
// Splits an LZRW1 byte stream into literal/copy items for decompressor_top.
// Optional item statistics are enabled with LZRW1_PARSER_STATS_EN.
module lzrw1_stream_parser
    import lzrw1_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] dec_data_in,
    output logic        dec_control_word,
    output logic        dec_data_valid,
    input  logic        decompressor_busy,
    output logic        block_done,
    output logic        format_error
`ifdef LZRW1_PARSER_STATS_EN
    ,
    output logic [LZRW1_COUNT_WIDTH-1:0] literal_count,
    output logic [LZRW1_COUNT_WIDTH-1:0] copy_count
`endif
);

    parser_state_t r_state;
    parser_state_t w_next_state;
    item_t         r_item;
    item_t         w_next_item;
    logic [7:0]    r_ctrl;
    logic [7:0]    w_next_ctrl;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_next_bit_idx;
    logic          r_last_seen;
    logic          w_next_last;
    logic          r_in_ready;
    logic          r_data_valid;
    logic          r_block_done;
    logic          r_format_error;
    logic          w_xfer;
    logic          w_flag;
    logic          w_accept;
    logic          w_drain_done;

    assign w_xfer = in_valid & r_in_ready;
    // Flags are consumed MSB first: bit 7 belongs to item 0.
    assign w_flag = r_ctrl[3'd7 - r_bit_idx];

    // Next-state, item capture and handshake decode.
    always_comb begin
        w_next_state   = r_state;
        w_next_item    = r_item;
        w_next_ctrl    = r_ctrl;
        w_next_bit_idx = r_bit_idx;
        w_next_last    = r_last_seen;
        w_accept       = 1'b0;
        w_drain_done   = 1'b0;
        case (r_state)
            GET_CW: begin
                if (w_xfer) begin
                    w_next_ctrl    = in_byte;
                    w_next_bit_idx = 3'd0;
                    w_next_last    = 1'b0;
                    w_next_state   = in_last ? DRAIN : GET_B0;
                end else begin
                    w_next_state = GET_CW;
                end
            end
            GET_B0: begin
                if (w_xfer) begin
                    w_next_item.is_copy = w_flag;
                    if (w_flag == LZRW1_COPY) begin
                        w_next_item.data = {in_byte, 8'h00};
                        w_next_state     = in_last ? ERROR : GET_B1;
                    end else begin
                        w_next_item.data = {8'h00, in_byte};
                        w_next_last      = in_last;
                        w_next_state     = PRESENT;
                    end
                end else begin
                    w_next_state = GET_B0;
                end
            end
            GET_B1: begin
                if (w_xfer) begin
                    w_next_item.data[7:0] = in_byte;
                    w_next_last           = in_last;
                    w_next_state          = PRESENT;
                end else begin
                    w_next_state = GET_B1;
                end
            end
            PRESENT: begin
                if (!decompressor_busy) begin
                    w_accept     = 1'b1;
                    w_next_state = GAP;
                end else begin
                    w_next_state = PRESENT;
                end
            end
            // One idle cycle lets the decompressor's registered busy rise first.
            GAP: begin
                if (r_last_seen) begin
                    w_next_state = DRAIN;
                end else if (r_bit_idx == 3'(LZRW1_GROUP_SIZE - 1)) begin
                    w_next_bit_idx = 3'd0;
                    w_next_state   = GET_CW;
                end else begin
                    w_next_bit_idx = r_bit_idx + 3'd1;
                    w_next_state   = GET_B0;
                end
            end
            DRAIN: begin
                if (!decompressor_busy) begin
                    w_drain_done = 1'b1;
                    w_next_state = GET_CW;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            ERROR: begin
                if (w_xfer && in_last) begin
                    w_next_state = GET_CW;
                end else begin
                    w_next_state = ERROR;
                end
            end
            default: begin
                w_next_state = GET_CW;
            end
        endcase
    end

    // State, item register and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= GET_CW;
            r_item         <= '0;
            r_ctrl         <= 8'h00;
            r_bit_idx      <= 3'd0;
            r_last_seen    <= 1'b0;
            r_in_ready     <= 1'b0;
            r_data_valid   <= 1'b0;
            r_block_done   <= 1'b0;
            r_format_error <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_item         <= w_next_item;
            r_ctrl         <= w_next_ctrl;
            r_bit_idx      <= w_next_bit_idx;
            r_last_seen    <= w_next_last;
            r_in_ready     <= (w_next_state == GET_CW) || (w_next_state == GET_B0) ||
                              (w_next_state == GET_B1) || (w_next_state == ERROR);
            r_data_valid   <= (w_next_state == PRESENT);
            r_block_done   <= w_drain_done;
            r_format_error <= r_format_error | (w_next_state == ERROR);
        end
    end

    assign in_ready         = r_in_ready;
    assign dec_data_in      = r_item.data;
    assign dec_control_word = r_item.is_copy;
    assign dec_data_valid   = r_data_valid;
    assign block_done       = r_block_done;
    assign format_error     = r_format_error;

`ifdef LZRW1_PARSER_STATS_EN
    logic [LZRW1_COUNT_WIDTH-1:0] r_literal_count;
    logic [LZRW1_COUNT_WIDTH-1:0] r_copy_count;

    // Per-block item statistics, restarted whenever a block completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_literal_count <= '0;
            r_copy_count    <= '0;
        end else if (w_drain_done) begin
            r_literal_count <= '0;
            r_copy_count    <= '0;
        end else if (w_accept) begin
            if (r_item.is_copy == LZRW1_COPY) begin
                r_copy_count <= sat_inc(r_copy_count);
            end else begin
                r_literal_count <= sat_inc(r_literal_count);
            end
        end else begin
            r_literal_count <= r_literal_count;
            r_copy_count    <= r_copy_count;
        end
    end

    assign literal_count = r_literal_count;
    assign copy_count    = r_copy_count;
`endif

endmodule

// File: tb/tb_lzrw1_stream_parser.sv
// Directed scoreboard bench for lzrw1_stream_parser.
module tb_lzrw1_stream_parser;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] dec_data_in;
    logic        dec_control_word;
    logic        dec_data_valid;
    logic        decompressor_busy = 1'b0;
    logic        block_done;
    logic        format_error;
`ifdef LZRW1_PARSER_STATS_EN
    logic [15:0] literal_count;
    logic [15:0] copy_count;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_accepts    = 0;
    int n_done       = 0;
    logic [16:0] exp_q[$];

    lzrw1_stream_parser dut (
        .clock             (clock),
        .reset             (reset),
        .in_byte           (in_byte),
        .in_valid          (in_valid),
        .in_last           (in_last),
        .in_ready          (in_ready),
        .dec_data_in       (dec_data_in),
        .dec_control_word  (dec_control_word),
        .dec_data_valid    (dec_data_valid),
        .decompressor_busy (decompressor_busy),
        .block_done        (block_done),
        .format_error      (format_error)
`ifdef LZRW1_PARSER_STATS_EN
        ,
        .literal_count     (literal_count),
        .copy_count        (copy_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: an item is consumed on the edge after a negedge with valid & !busy.
    always @(negedge clock) begin
        if (reset) begin
            if (block_done) n_done++;
            if (dec_data_valid && !decompressor_busy) begin
                n_accepts++;
                if (exp_q.size() > 0) begin
                    check("item", {15'h0, dec_data_in, dec_control_word}, {15'h0, exp_q.pop_front()});
                end else begin
                    check("unexpected_item", 32'(exp_q.size()), 32'd1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic last);
        int waited;
        @(negedge clock);
        in_byte  = b;
        in_valid = 1'b1;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic lit(input logic [7:0] b, input logic last);
        exp_q.push_back({8'h00, b, 1'b0});
        send(b, last);
    endtask

    task automatic wait_done(input int target);
        int waited = 0;
        while ((n_done < target || exp_q.size() != 0) && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        @(negedge clock);
        check("block_done_count", 32'(n_done), 32'(target));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {26'h0, in_ready, dec_data_valid, dec_control_word, block_done, format_error, 1'b0},
              32'd0);
        check(tag, {16'h0, dec_data_in}, 32'd0);
    endtask

    initial begin
        int acc_before;
        #12;
        check_outputs_zero("reset_state");
        @(posedge clock);
        #1 reset = 1'b1;

        // 1: three literals; first item valid the cycle after its byte lands
        send(8'h00, 1'b0);
        lit(8'h61, 1'b0);
        @(negedge clock);
        check("latency_valid", 32'(dec_data_valid), 32'd1);
        lit(8'h62, 1'b0);
        lit(8'h63, 1'b1);
        wait_done(1);

        // 2: literal, copy, literal
        send(8'h40, 1'b0);
        lit(8'h78, 1'b0);
        exp_q.push_back({16'h1234, 1'b1});
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        lit(8'h79, 1'b1);
        wait_done(2);

        // 3: full group of literals then a second control byte with a copy
        send(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) lit(8'h41 + 8'(i), 1'b0);
        send(8'h80, 1'b0);
        exp_q.push_back({16'hABCD, 1'b1});
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b1);
        wait_done(3);

        // 4: backpressure while an item is presented
        @(posedge clock);
        #1 decompressor_busy = 1'b1;
        acc_before = n_accepts;
        send(8'h00, 1'b0);
        lit(8'h68, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("hold_data", {15'h0, dec_data_in, dec_control_word}, {15'h0, 16'h0068, 1'b0});
            check("hold_valid_ready", {30'h0, dec_data_valid, in_ready}, 32'h2);
        end
        @(posedge clock);
        #1 decompressor_busy = 1'b0;
        wait_done(4);
        check("single_accept", 32'(n_accepts - acc_before), 32'd1);

        // 5: in_last between copy bytes, then recovery
        acc_before = n_accepts;
        send(8'h80, 1'b0);
        send(8'h12, 1'b1);
        @(negedge clock);
        check("format_error_set", 32'(format_error), 32'd1);
        check("no_item_on_error", 32'(dec_data_valid), 32'd0);
        send(8'h5A, 1'b1);
        check("error_no_accept", 32'(n_accepts - acc_before), 32'd0);
        send(8'h00, 1'b0);
        lit(8'h6B, 1'b1);
        wait_done(5);
        check("format_error_sticky", 32'(format_error), 32'd1);

        // 6: asynchronous reset in the middle of a copy
        send(8'h80, 1'b0);
        send(8'h12, 1'b0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clock);
        #1 reset = 1'b1;
        send(8'h00, 1'b0);
        lit(8'h71, 1'b1);
        wait_done(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
